// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Types and widths shared by the UART transmit-side blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_BYTE_W  = 8;
    localparam int UART_GUARD_W = 8;

    // Transmit scheduler sequencing states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_DRAIN  = 3'd3,
        S_GAP    = 3'd4
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous byte FIFO with push/pop/flush. Head entry is
//               visible combinationally so a pop can capture it directly.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [UART_BYTE_W-1:0] data_i,
    input  logic                   pop_i,
    input  logic                   clr_i,
    output logic [UART_BYTE_W-1:0] head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [AW:0]            level_o
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [UART_BYTE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Flush wins over both push and pop; writes into a full FIFO are dropped
    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);
    assign w_push  = push_i && !w_full && !clr_i;
    assign w_pop   = pop_i && !w_empty && !clr_i;

    // Storage array; no reset needed, contents are qualified by the count
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_o  = r_mem[r_rd_ptr];
    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign level_o = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched
// Description : Transmit-side sequencer. Queues bytes from the bus side and
//               launches one frame at a time into the UART transmitter core,
//               waiting for the core's done pulse to rise and fall, plus an
//               optional idle guard gap, before the next launch.
//               Optional feature macro: UART_TX_SCHED_WM_EN (adds wm_i and a
//               registered low-watermark interrupt wm_irq_o).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    sched_en_i,
    input  logic                    fifo_clr_i,
    input  logic [UART_GUARD_W-1:0] guard_i,
    input  logic [UART_BYTE_W-1:0]  wdata_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [AW:0]             level_o,
    output logic                    tx_en_o,
    output logic [UART_BYTE_W-1:0]  tx_byte_o,
    input  logic                    tx_done_i,
    output logic                    busy_o
`ifdef UART_TX_SCHED_WM_EN
    ,
    input  logic [AW:0]             wm_i,
    output logic                    wm_irq_o
`endif
);

    sched_state_e              r_state;
    logic                      r_tx_en;
    logic [UART_BYTE_W-1:0]    r_tx_byte;
    logic [UART_GUARD_W-1:0]   r_guard_cnt;

    logic [UART_BYTE_W-1:0]    w_head;
    logic                      w_full;
    logic                      w_empty;
    logic [AW:0]               w_level;
    logic                      w_launch;

    // A launch pops the head; a same-cycle flush suppresses it so nothing
    // flushed can still go out on the line
    assign w_launch = (r_state == S_IDLE) && sched_en_i && !w_empty && !fifo_clr_i;

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (wvalid_i),
        .data_i  (wdata_i),
        .pop_i   (w_launch),
        .clr_i   (fifo_clr_i),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (w_level)
    );

    // Frame sequencer: launch, wait done high, wait done low, optional gap
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_tx_en     <= 1'b0;
            r_tx_byte   <= '0;
            r_guard_cnt <= '0;
        end else begin
            r_tx_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_tx_byte <= w_head;
                        r_tx_en   <= 1'b1;
                        r_state   <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_done_i) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!tx_done_i) begin
                        if (guard_i != '0) begin
                            r_guard_cnt <= guard_i;
                            r_state     <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    r_guard_cnt <= r_guard_cnt - 1'b1;
                    if (r_guard_cnt == UART_GUARD_W'(1)) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wready_o  = !w_full;
    assign level_o   = w_level;
    assign tx_en_o   = r_tx_en;
    assign tx_byte_o = r_tx_byte;
    assign busy_o    = (r_state != S_IDLE) || (w_level != '0);

`ifdef UART_TX_SCHED_WM_EN
    logic r_wm_irq;

    // Low-watermark interrupt level, only while the scheduler is enabled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wm_irq <= 1'b0;
        end else begin
            r_wm_irq <= (w_level <= wm_i) && sched_en_i;
        end
    end

    assign wm_irq_o = r_wm_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_sched
// Description : Directed self-checking bench for uart_tx_sched with a simple
//               transmitter-core model (done rises FRAME clocks after launch
//               and stays high DONE_W clocks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    localparam int FRAME  = 3;
    localparam int DONE_W = 2;

    logic       clk;
    logic       rst_ni;
    logic       sched_en_i;
    logic       fifo_clr_i;
    logic [7:0] guard_i;
    logic [7:0] wdata_i;
    logic       wvalid_i;
    logic       wready_o;
    logic [3:0] level_o;
    logic       tx_en_o;
    logic [7:0] tx_byte_o;
    logic       tx_done_i = 1'b0;
    logic       busy_o;
    logic [3:0] wm_i;
    logic       wm_irq_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Core model state and launch log
    int         ph     = 0;
    bit         active = 1'b0;
    logic [7:0] lb[$];
    int         lc[$];
    int         fq[$];

    uart_tx_sched #(
        .DEPTH (8),
        .AW    (3)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .sched_en_i (sched_en_i),
        .fifo_clr_i (fifo_clr_i),
        .guard_i    (guard_i),
        .wdata_i    (wdata_i),
        .wvalid_i   (wvalid_i),
        .wready_o   (wready_o),
        .level_o    (level_o),
        .tx_en_o    (tx_en_o),
        .tx_byte_o  (tx_byte_o),
        .tx_done_i  (tx_done_i),
        .busy_o     (busy_o)
`ifdef UART_TX_SCHED_WM_EN
        ,
        .wm_i       (wm_i),
        .wm_irq_o   (wm_irq_o)
`endif
    );

`ifndef UART_TX_SCHED_WM_EN
    assign wm_irq_o = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter: number of rising edges seen
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter core model, evaluated on falling edges
    always @(negedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            active    = 1'b0;
            ph        = 0;
            tx_done_i = 1'b0;
        end else begin
            if (tx_en_o) begin
                lb.push_back(tx_byte_o);
                lc.push_back(cyc);
                active = 1'b1;
                ph     = 0;
            end else if (active) begin
                ph = ph + 1;
            end
            if (tx_done_i && !(active && ph >= FRAME && ph < FRAME + DONE_W))
                fq.push_back(cyc);
            tx_done_i = active && ph >= FRAME && ph < FRAME + DONE_W;
            if (ph >= FRAME + DONE_W) active = 1'b0;
        end
    end

    task automatic clear_log();
        lb.delete();
        lc.delete();
        fq.delete();
    endtask

    task automatic write_byte(input logic [7:0] b);
        wdata_i  = b;
        wvalid_i = 1'b1;
        @(negedge clk);
        wvalid_i = 1'b0;
        wdata_i  = 8'h00;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 300 && (busy_o || tx_done_i || active); k++) @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle_timeout: busy_o=%b required 0", tag, busy_o);
        end
    endtask

    task automatic test_reset();
        int seen;
        // Initial reset state
        rst_ni = 1'b0; sched_en_i = 1'b0; fifo_clr_i = 1'b0; guard_i = 8'd0;
        wdata_i = 8'h00; wvalid_i = 1'b0; wm_i = 4'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tx_en_o, tx_byte_o, level_o, busy_o, wready_o} !== {1'b0, 8'h00, 4'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs: tx_en=%b byte=%h level=%0d busy=%b wready=%b required 0,00,0,0,1",
                     tx_en_o, tx_byte_o, level_o, busy_o, wready_o);
        end
        rst_ni = 1'b1;
        @(negedge clk);
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
        n_checks++;
        if (level_o !== 4'd3) begin
            n_fail++;
            $display("FAIL reset_prefill_level: got %0d required 3", level_o);
        end
        // Assert reset with bytes queued and the scheduler enabled
        rst_ni = 1'b0; sched_en_i = 1'b1;
        #1;
        n_checks++;
        if (level_o !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_async_level: got %0d required 0", level_o);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (tx_en_o) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_no_launch_in_reset: tx_en seen %0d cycles required 0", seen);
        end
        clear_log();
        rst_ni = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (level_o !== 4'd0 || busy_o !== 1'b0 || lc.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_after_release: level=%0d busy=%b launches=%0d required 0,0,0",
                     level_o, busy_o, lc.size());
        end
        sched_en_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n;
        clear_log();
        guard_i = 8'd0;
        write_byte(8'hA5);
        write_byte(8'h3C);
        sched_en_i = 1'b1;
        n = cyc;
        for (int i = 0; i < 100 && lc.size() < 2; i++) @(negedge clk);
        n_checks++;
        if (lc.size() < 2) begin
            n_fail++;
            $display("FAIL b2b_launch_timeout: launches=%0d required 2", lc.size());
        end else begin
            n_checks++;
            if (lb[0] !== 8'hA5 || lb[1] !== 8'h3C) begin
                n_fail++;
                $display("FAIL b2b_bytes: got %h,%h required a5,3c", lb[0], lb[1]);
            end
            n_checks++;
            if (lc[0] !== n + 1) begin
                n_fail++;
                $display("FAIL b2b_first_latency: launch at %0d required %0d", lc[0], n + 1);
            end
            n_checks++;
            if (fq.size() < 1 || lc[1] !== fq[0] + 2) begin
                n_fail++;
                $display("FAIL b2b_after_done_fall: 2nd launch %0d, falls=%0d required fall+2",
                         lc[1], fq.size());
            end
            n_checks++;
            if (lc[1] - lc[0] !== 7) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d required 7", lc[1] - lc[0]);
            end
        end
        wait_idle("b2b");
        n_checks++;
        if (tx_byte_o !== 8'h3C || lc.size() !== 2) begin
            n_fail++;
            $display("FAIL b2b_hold: byte=%h launches=%0d required 3c,2", tx_byte_o, lc.size());
        end
        sched_en_i = 1'b0;
    endtask

    task automatic test_guard();
        clear_log();
        guard_i = 8'd5;
        write_byte(8'h11);
        write_byte(8'h22);
        sched_en_i = 1'b1;
        for (int i = 0; i < 100 && lc.size() < 2; i++) @(negedge clk);
        n_checks++;
        if (lc.size() < 2 || fq.size() < 1) begin
            n_fail++;
            $display("FAIL guard_launch_timeout: launches=%0d required 2", lc.size());
        end else begin
            n_checks++;
            if (lc[1] - fq[0] !== 7) begin
                n_fail++;
                $display("FAIL guard_gap: fall-to-launch %0d required 7", lc[1] - fq[0]);
            end
            n_checks++;
            if (lc[1] - lc[0] !== 12) begin
                n_fail++;
                $display("FAIL guard_spacing: got %0d required 12", lc[1] - lc[0]);
            end
        end
        wait_idle("guard");
        sched_en_i = 1'b0;
        guard_i    = 8'd0;
    endtask

    task automatic test_full_clr();
        clear_log();
        for (int i = 0; i < 8; i++) write_byte(8'h80 + 8'(i));
        n_checks++;
        if (wready_o !== 1'b0 || level_o !== 4'd8) begin
            n_fail++;
            $display("FAIL full_flags: wready=%b level=%0d required 0,8", wready_o, level_o);
        end
        write_byte(8'h99);
        n_checks++;
        if (level_o !== 4'd8 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_drop: level=%0d busy=%b required 8,1", level_o, busy_o);
        end
        sched_en_i = 1'b1;
        for (int i = 0; i < 20 && lc.size() < 1; i++) @(negedge clk);
        @(negedge clk);
        fifo_clr_i = 1'b1;
        @(negedge clk);
        fifo_clr_i = 1'b0;
        n_checks++;
        if (level_o !== 4'd0 || wready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_level: level=%0d wready=%b required 0,1", level_o, wready_o);
        end
        wait_idle("clr");
        repeat (10) @(negedge clk);
        n_checks++;
        if (lc.size() !== 1 || fq.size() !== 1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_single_frame: launches=%0d frames_done=%0d busy=%b required 1,1,0",
                     lc.size(), fq.size(), busy_o);
        end else begin
            n_checks++;
            if (lb[0] !== 8'h80) begin
                n_fail++;
                $display("FAIL clr_frame_byte: got %h required 80", lb[0]);
            end
        end
        sched_en_i = 1'b0;
    endtask

    task automatic test_sched_en();
        clear_log();
        write_byte(8'h51); write_byte(8'h52); write_byte(8'h53);
        sched_en_i = 1'b1;
        for (int i = 0; i < 20 && lc.size() < 1; i++) @(negedge clk);
        @(negedge clk);
        sched_en_i = 1'b0;
        repeat (30) @(negedge clk);
        n_checks++;
        if (lc.size() !== 1 || fq.size() !== 1 || level_o !== 4'd2 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL en_hold: launches=%0d done=%0d level=%0d busy=%b required 1,1,2,1",
                     lc.size(), fq.size(), level_o, busy_o);
        end else begin
            n_checks++;
            if (lb[0] !== 8'h51) begin
                n_fail++;
                $display("FAIL en_first_byte: got %h required 51", lb[0]);
            end
        end
        sched_en_i = 1'b1;
        for (int i = 0; i < 100 && lc.size() < 3; i++) @(negedge clk);
        wait_idle("en");
        n_checks++;
        if (lc.size() !== 3) begin
            n_fail++;
            $display("FAIL en_resume_count: launches=%0d required 3", lc.size());
        end else begin
            n_checks++;
            if (lb[1] !== 8'h52 || lb[2] !== 8'h53 || level_o !== 4'd0) begin
                n_fail++;
                $display("FAIL en_resume_bytes: got %h,%h level=%0d required 52,53,0",
                         lb[1], lb[2], level_o);
            end
        end
        sched_en_i = 1'b0;
    endtask

`ifdef UART_TX_SCHED_WM_EN
    task automatic test_watermark();
        bit hit;
        clear_log();
        wm_i = 4'd2;
        @(negedge clk);
        for (int i = 0; i < 4; i++) write_byte(8'hC0 + 8'(i));
        n_checks++;
        if (wm_irq_o !== 1'b0 || level_o !== 4'd4) begin
            n_fail++;
            $display("FAIL wm_initial: irq=%b level=%0d required 0,4", wm_irq_o, level_o);
        end
        sched_en_i = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (level_o == 4'd2) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL wm_level_timeout: level=%0d required 2", level_o);
        end else begin
            n_checks++;
            if (wm_irq_o !== 1'b0) begin
                n_fail++;
                $display("FAIL wm_irq_same_cycle: got %b required 0", wm_irq_o);
            end
            @(negedge clk);
            n_checks++;
            if (wm_irq_o !== 1'b1) begin
                n_fail++;
                $display("FAIL wm_irq_rise: got %b required 1", wm_irq_o);
            end
            write_byte(8'hD0); write_byte(8'hD1); write_byte(8'hD2);
            n_checks++;
            if (level_o !== 4'd5 || wm_irq_o !== 1'b0) begin
                n_fail++;
                $display("FAIL wm_irq_clear: level=%0d irq=%b required 5,0", level_o, wm_irq_o);
            end
        end
        wait_idle("wm");
        sched_en_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_guard();
        test_full_clr();
        test_sched_en();
`ifdef UART_TX_SCHED_WM_EN
        test_watermark();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
